reflet_timer: RTL and testbench
===============================

# reflet_timer

Memory-mapped interval timer for the reflet CPU bus. It sits downstream of `reflet_cpu` on the shared `addr`/`data_out`/`write_en` bus and drives one bit of the CPU's 4-bit `interrupt_request` input. It provides a prescaled up-counter, a compare match with optional auto-reload, and a sticky interrupt flag, so firmware can run periodic or one-shot interrupt contexts.

## Interface
- `wordsize`, 16: bus/register width in bits; must be 16, 32 or 64.
- `base_addr`, 16'hFF00: byte address of register 0; aligned to 8·(wordsize/8).
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `addr` input wordsize: CPU byte address.
- `data_in` input wordsize: CPU write data (CPU `data_out`).
- `write_en` input 1: CPU write strobe.
- `data_out` output wordsize: read data, ORed by the integrator into CPU `data_in`.
- `irq` output 1: level interrupt request to one `interrupt_request` bit.

## Operation
- Register stride is wordsize/8 bytes. Offset index = (addr − base_addr)/stride. Selected when the index is 0..4 and addr is stride-aligned. Unaligned or out-of-range accesses are ignored and read as 0.
- 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Other bits read 0.
- 1 PRESCALE: the tick fires every PRESCALE+1 cycles while EN=1.
- 2 COMPARE: match value.
- 3 COUNT: current count; R/W.
- 4 STATUS: bit0 PEND. Writing 1 to bit0 clears it; writing 0 has no effect.
- Prescaler `pre_cnt` (wordsize bits, internal):
  - EN=0: holds at 0.
  - EN=1: if pre_cnt==PRESCALE, it goes to 0 and asserts tick for that cycle; otherwise it increments.
- On tick:
  - If COUNT==COMPARE: PEND←1. If AUTO, COUNT←0. If not AUTO, COUNT holds and EN←0 (one-shot).
  - Otherwise COUNT←COUNT+1, wrapping modulo 2^wordsize.
- `irq` = PEND & IE. It is combinational from registers, so it is glitch-free.
- Priorities for the same cycle:
  - A write to COUNT beats the tick update.
  - A write to PRESCALE does not reset pre_cnt.
  - A write to CTRL clearing EN also zeroes pre_cnt.
  - A STATUS clear and a tick-set in the same cycle leave PEND=1 (set wins).
- States, derived from EN/AUTO: IDLE (EN=0), RUN_PERIODIC (EN=1, AUTO=1), RUN_ONESHOT (EN=1, AUTO=0). RUN_ONESHOT returns to IDLE on match.

## Timing
- Writes take effect on the clock edge where write_en=1. The new value is visible from the next cycle.
- Reads are registered with 1-cycle latency, matching the synchronous ROM. `data_out` in cycle n+1 reflects the register value sampled at edge n (pre-update). It is 0 when the access was not selected or write_en=1.
- Reset: CTRL=0, PRESCALE=0, COMPARE=0, COUNT=0, PEND=0, pre_cnt=0, data_out=0, irq=0. A reset mid-count discards all progress.
- With PRESCALE=0 the tick occurs every cycle while EN=1, starting the cycle after EN is written.
- Periodic period = (PRESCALE+1)·(COMPARE+1) cycles. The first PEND rises (PRESCALE+1)·(COMPARE+1) cycles after the EN write edge.
- COMPARE=0 with AUTO=1 sets PEND on every tick.

## Structure
- Shared package `reflet_timer_pkg`: register offset constants (CTRL=0 … STATUS=4) and CTRL bit indices (EN=0, AUTO=1, IE=2).
- One sub-module `reflet_timer_prescaler` (EN, PRESCALE → tick). The address decode, registers and compare logic live in the top module.

## Test plan
- Reset: hold reset=1 for 3 cycles with random bus traffic → all registers read 0, and irq=0 throughout.
- Periodic: PRESCALE=1, COMPARE=3, CTRL=0b111 → PEND/irq rise 8 cycles after the EN edge. Clear STATUS; the next rise comes 8 cycles after the previous one, and COUNT cycles 0,1,2,3,0.
- One-shot: PRESCALE=0, COMPARE=5, CTRL=0b101 → irq rises 6 cycles after EN. CTRL then reads 0b100, COUNT stays 5, and no further ticks occur.
- Collisions:
  - Write COUNT=2 on a tick edge → COUNT reads 2, not the incremented value.
  - Write STATUS=1 on a match edge → PEND stays 1.
- Masking: IE=0 with a match → STATUS bit0=1 and irq=0. Setting IE=1 raises irq the next cycle.
- Decode: read/write base_addr+1 (unaligned) and base_addr+5·stride → no register changes, and data_out=0 one cycle later.

Source files
------------

// File: rtl/reflet_timer_pkg.sv
// Shared definitions for the reflet interval timer: register offsets and CTRL bit positions.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package reflet_timer_pkg;

  // Register indices (byte offset = index * stride)
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam int         NUM_REGS     = 5;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_W    = 3;

  // Run mode is not stored; it is always decoded from EN/AUTO
  typedef enum logic [1:0] {
    MODE_IDLE     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2
  } mode_t;

  function automatic mode_t ctrl_mode(input logic [CTRL_W-1:0] ctrl);
    if (!ctrl[CTRL_EN]) begin
      return MODE_IDLE;
    end else if (ctrl[CTRL_AUTO]) begin
      return MODE_PERIODIC;
    end else begin
      return MODE_ONESHOT;
    end
  endfunction

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Prescaler: emits a one-cycle tick every PRESCALE+1 cycles while enabled.
// Latency: tick is combinational from the internal counter; counter updates on the rising edge.
// Backpressure: none; the counter free-runs while enabled and holds at 0 otherwise.
module reflet_timer_prescaler #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [wordsize-1:0] i_prescale,
  output logic                o_tick
);

  logic [wordsize-1:0] r_pre_cnt;
  logic                w_wrap;

  assign w_wrap = (r_pre_cnt == i_prescale);
  assign o_tick = i_en && w_wrap;

  // Count up to PRESCALE then wrap; forced to 0 while disabled or when EN is being cleared.
  // A PRESCALE change does not restart the count.
  always_ff @(posedge clk) begin
    if (reset || !i_en || i_clr) begin
      r_pre_cnt <= '0;
    end else if (w_wrap) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + wordsize'(1);
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped interval timer: prescaled up-counter, compare match, auto-reload/one-shot, sticky IRQ.
// Latency: writes land on the write_en edge; reads return one cycle later; irq is combinational from registers.
// Backpressure: none; every bus access completes in a single cycle.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam int STRIDE_SHIFT = $clog2(wordsize / 8);

  logic [CTRL_W-1:0]   r_ctrl;
  logic [wordsize-1:0] r_prescale;
  logic [wordsize-1:0] r_compare;
  logic [wordsize-1:0] r_count;
  logic                r_pend;
  logic [wordsize-1:0] r_data_out;

  logic [wordsize-1:0] w_offset;
  logic [wordsize-1:0] w_index;
  logic [2:0]          w_reg;
  logic                w_sel;
  logic                w_wr;
  logic                w_rd;
  logic                w_tick;
  logic                w_match;
  logic                w_set_pend;
  logic                w_clr_pre;
  logic [wordsize-1:0] w_rd_dat;
  mode_t               w_mode;

  // Address decode: addresses below base wrap to a huge offset and fall out of range
  assign w_offset   = addr - base_addr;
  assign w_index    = w_offset >> STRIDE_SHIFT;
  assign w_sel      = (w_offset[STRIDE_SHIFT-1:0] == '0) && (w_index < wordsize'(NUM_REGS));
  assign w_reg      = w_index[2:0];
  assign w_wr       = w_sel && write_en;
  assign w_rd       = w_sel && !write_en;

  assign w_mode     = ctrl_mode(r_ctrl);
  assign w_match    = (r_count == r_compare);
  assign w_set_pend = w_tick && w_match;
  assign w_clr_pre  = w_wr && (w_reg == REG_CTRL) && !data_in[CTRL_EN];

  assign irq        = r_pend && r_ctrl[CTRL_IE];
  assign data_out   = r_data_out;

  reflet_timer_prescaler #(
    .wordsize(wordsize)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_clr     (w_clr_pre),
    .i_prescale(r_prescale),
    .o_tick    (w_tick)
  );

  // Read mux over the current (pre-update) register values
  always_comb begin
    w_rd_dat = '0;
    case (w_reg)
      REG_CTRL:     w_rd_dat = wordsize'(r_ctrl);
      REG_PRESCALE: w_rd_dat = r_prescale;
      REG_COMPARE:  w_rd_dat = r_compare;
      REG_COUNT:    w_rd_dat = r_count;
      REG_STATUS:   w_rd_dat = wordsize'(r_pend);
      default:      w_rd_dat = '0;
    endcase
  end

  // Timer state: tick update first, then bus writes override (COUNT/CTRL writes win over the tick)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_compare  <= '0;
      r_count    <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_tick) begin
        if (w_match) begin
          r_pend <= 1'b1;
          if (w_mode == MODE_PERIODIC) begin
            r_count <= '0;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
          end
        end else begin
          r_count <= r_count + wordsize'(1);
        end
      end
      if (w_wr) begin
        case (w_reg)
          REG_CTRL:     r_ctrl     <= data_in[CTRL_W-1:0];
          REG_PRESCALE: r_prescale <= data_in;
          REG_COMPARE:  r_compare  <= data_in;
          REG_COUNT:    r_count    <= data_in;
          REG_STATUS: begin
            // Write-1-to-clear; a match on the same edge keeps PEND set
            if (data_in[0] && !w_set_pend) begin
              r_pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered read data; zero for writes and unselected addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (w_rd) begin
      r_data_out <= w_rd_dat;
    end else begin
      r_data_out <= '0;
    end
  end

endmodule

// File: tb/tb_reflet_timer.sv
// Bench for reflet_timer: directed scenarios followed by random bus traffic against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_reflet_timer;

  localparam int             W      = 16;
  localparam int             STRIDE = W / 8;
  localparam logic [W-1:0]   BASE   = 16'hFF00;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] addr;
  logic [W-1:0] data_in;
  logic         write_en;
  logic [W-1:0] data_out;
  logic         irq;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed directly in register terms
  logic [2:0]   m_ctrl;
  logic [W-1:0] m_psc;
  logic [W-1:0] m_cmp;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_phase;
  logic         m_pend;
  logic [W-1:0] m_dout;

  reflet_timer #(
    .wordsize (W),
    .base_addr(BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .data_in (data_in),
    .write_en(write_en),
    .data_out(data_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ra(input int idx);
    return BASE + W'(idx * STRIDE);
  endfunction

  // One clock edge of the timer as the register map describes it
  task automatic model_step(input logic rst, input logic [W-1:0] a, input logic [W-1:0] d,
                            input logic we);
    int           off;
    int           idx;
    bit           sel;
    bit           tick;
    bit           hit;
    logic [W-1:0] rv;
    logic [2:0]   n_ctrl;
    logic [W-1:0] n_psc, n_cmp, n_cnt, n_phase;
    logic         n_pend;

    off = int'(a) - int'(BASE);
    sel = (off >= 0) && (off % STRIDE == 0) && (off / STRIDE < 5);
    idx = sel ? off / STRIDE : -1;
    case (idx)
      0:       rv = W'(m_ctrl);
      1:       rv = m_psc;
      2:       rv = m_cmp;
      3:       rv = m_cnt;
      4:       rv = W'(m_pend);
      default: rv = '0;
    endcase

    tick = m_ctrl[0] && (m_phase == m_psc);
    hit  = tick && (m_cnt == m_cmp);
    n_ctrl = m_ctrl; n_psc = m_psc; n_cmp = m_cmp; n_cnt = m_cnt; n_pend = m_pend;
    n_phase = (!m_ctrl[0] || tick) ? '0 : m_phase + W'(1);

    if (tick) begin
      if (hit) begin
        n_pend = 1'b1;
        if (m_ctrl[1]) n_cnt = '0;
        else           n_ctrl[0] = 1'b0;
      end else begin
        n_cnt = m_cnt + W'(1);
      end
    end

    if (sel && we) begin
      case (idx)
        0: begin n_ctrl = d[2:0]; if (!d[0]) n_phase = '0; end
        1: n_psc = d;
        2: n_cmp = d;
        3: n_cnt = d;
        4: if (d[0] && !hit) n_pend = 1'b0;
        default: ;
      endcase
    end

    m_dout = (sel && !we) ? rv : '0;
    if (rst) begin
      n_ctrl = '0; n_psc = '0; n_cmp = '0; n_cnt = '0; n_phase = '0; n_pend = 1'b0;
      m_dout = '0;
    end
    m_ctrl = n_ctrl; m_psc = n_psc; m_cmp = n_cmp; m_cnt = n_cnt; m_phase = n_phase;
    m_pend = n_pend;
  endtask

  // Apply one bus cycle, then compare data_out and irq against the model
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] d, input logic we);
    addr     = a;
    data_in  = d;
    write_en = we;
    model_step(reset, a, d, we);
    @(posedge clk);
    #1;
    chk("dout", data_out, m_dout);
    chk("irq", irq, m_pend & m_ctrl[2]);
  endtask

  task automatic wr(input int idx, input logic [W-1:0] v);
    drive(ra(idx), v, 1'b1);
  endtask

  task automatic rd(input int idx, output logic [W-1:0] v);
    drive(ra(idx), '0, 1'b0);
    v = data_out;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0);
  endtask

  // Number of idle edges until irq is high; 0 if it never rises within the limit
  task automatic wait_irq(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      idle();
      if (irq === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [W-1:0] v;
    int           n;
    int           k;
    logic [W-1:0] a;
    logic [W-1:0] d;

    reset = 1'b1; addr = '0; data_in = '0; write_en = 1'b0;

    // Reset held for 3 cycles under random bus traffic
    for (int i = 0; i < 3; i++) begin
      drive(ra($urandom_range(0, 4)), W'($urandom), 1'($urandom_range(0, 1)));
      chk("rst_irq", irq, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(i, v);
      chk("rst_reg", v, 0);
    end

    // Periodic: (1+1)*(3+1) = 8 cycles per interrupt
    wr(1, 1); wr(2, 3); wr(0, 7);
    wait_irq(40, n);
    chk("per_first", n, 8);
    wr(4, 1);
    wait_irq(40, n);
    chk("per_period", n + 1, 8);
    for (int i = 0; i < 9; i++) begin
      rd(3, v);
      chk("per_count", v, (i / 2) % 4);
    end
    wr(0, 0); wr(4, 1); wr(3, 0);

    // One-shot: 6 cycles, then EN drops and COUNT freezes
    wr(1, 0); wr(2, 5); wr(0, 5);
    wait_irq(40, n);
    chk("os_delay", n, 6);
    rd(0, v); chk("os_ctrl", v, 4);
    rd(3, v); chk("os_count", v, 5);
    for (int i = 0; i < 10; i++) idle();
    rd(3, v); chk("os_hold", v, 5);
    rd(4, v); chk("os_pend", v, 1);
    wr(0, 0); wr(4, 1);
    chk("os_cleared", irq, 0);

    // COUNT write on a tick edge wins over the increment
    wr(3, 0); wr(2, 100); wr(1, 0); wr(0, 1);
    idle(); idle();
    wr(3, 2);
    rd(3, v); chk("col_cnt", v, 2);
    rd(3, v); chk("col_cnt_next", v, 3);
    wr(0, 0);

    // STATUS clear on a match edge leaves PEND set
    wr(3, 0); wr(2, 3); wr(4, 1); wr(0, 3);
    idle(); idle(); idle();
    wr(4, 1);
    rd(4, v); chk("col_pend", v, 1);

    // Masking: pending but IE=0 -> no irq; enabling IE raises it next cycle
    chk("mask_irq", irq, 0);
    wr(0, 7);
    chk("mask_ie", irq, 1);
    wr(0, 0); wr(4, 1);

    // Decode: unaligned, past-the-end and below-base accesses are ignored
    wr(2, 16'h1234); wr(1, 16'h0003); wr(3, 16'h0042);
    drive(BASE + W'(1), 16'hFFFF, 1'b1);
    drive(ra(5), 16'hFFFF, 1'b1);
    drive(BASE - W'(2), 16'hFFFF, 1'b1);
    drive(BASE + W'(1), '0, 1'b0); chk("dec_unal", data_out, 0);
    drive(ra(5), '0, 1'b0);        chk("dec_oor", data_out, 0);
    rd(0, v); chk("dec_ctrl", v, 0);
    rd(1, v); chk("dec_psc", v, 16'h0003);
    rd(2, v); chk("dec_cmp", v, 16'h1234);
    rd(3, v); chk("dec_cnt", v, 16'h0042);
    rd(4, v); chk("dec_stat", v, 0);

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      k = $urandom_range(0, 6);
      case (k)
        0:       begin a = ra(0); d = W'($urandom_range(0, 7)); end
        1:       begin a = ra(1); d = W'($urandom_range(0, 3)); end
        2:       begin a = ra(2); d = W'($urandom_range(0, 6)); end
        3:       begin a = ra(3); d = W'($urandom_range(0, 8)); end
        4:       begin a = ra(4); d = W'($urandom_range(0, 1)); end
        5:       begin a = ra(5); d = W'($urandom); end
        default: begin a = BASE + W'(1); d = W'($urandom); end
      endcase
      drive(a, d, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
